// File: rtl/pwm_cmd_arbiter.sv
// PWM command arbiter: merges Raspberry Pi (Wishbone) and SAM MCU duty
// commands into one 4-channel frame. Only the owning source may commit.
// An arm/failsafe state machine with a command watchdog falls back to a
// safe duty when the owner stops committing.
module pwm_cmd_arbiter #(
  parameter int                    DUTY_WIDTH = 16,
  parameter int                    WDT_CYCLES = 20000000,
  parameter logic [DUTY_WIDTH-1:0] SAFE_DUTY  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [13:0]           wb_adr_i,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  input  logic                  mcu_wr,
  input  logic [1:0]            mcu_ch,
  input  logic [DUTY_WIDTH-1:0] mcu_duty,
  input  logic                  mcu_commit,
  output logic [DUTY_WIDTH-1:0] duty0_o,
  output logic [DUTY_WIDTH-1:0] duty1_o,
  output logic [DUTY_WIDTH-1:0] duty2_o,
  output logic [DUTY_WIDTH-1:0] duty3_o,
  output logic                  duty_upd,
  output logic                  armed,
  output logic                  failsafe
);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_FAILSAFE = 2'd2;

  localparam int             WDT_W    = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [DUTY_WIDTH-1:0] pi_shadow  [4];
  logic [DUTY_WIDTH-1:0] mcu_shadow [4];
  logic [DUTY_WIDTH-1:0] mcu_eff    [4];
  logic [DUTY_WIDTH-1:0] duty_q     [4];

  logic [1:0]       state;
  logic             owner;
  logic             arm_req;
  logic [7:0]       drop_count;
  logic [WDT_W-1:0] wdt;

  logic       wb_acc, wb_wr, wb_rd;
  logic [2:0] adr;
  logic       pi_commit, ctrl_wr;
  logic       is_armed, owner_commit, other_commit;
  logic       accept, drop, arm_next, disarm_req, wdt_expire;
  logic       unused_adr;

  assign wb_acc = wb_stb_i & wb_cyc_i;
  assign wb_wr  = wb_acc & wb_we_i;
  assign wb_rd  = wb_acc & ~wb_we_i;
  assign adr    = wb_adr_i[2:0];
  assign unused_adr = ^wb_adr_i[13:3];

  assign pi_commit = wb_wr && (adr == 3'd4);
  assign ctrl_wr   = wb_wr && (adr == 3'd5);

  assign is_armed     = (state == ST_ARMED);
  assign owner_commit = owner ? mcu_commit : pi_commit;
  assign other_commit = owner ? pi_commit  : mcu_commit;
  assign accept       = is_armed & owner_commit;
  assign drop         = is_armed & other_commit;
  assign arm_next     = ctrl_wr ? wb_dat_i[0] : arm_req;
  assign disarm_req   = is_armed & ctrl_wr & ~wb_dat_i[0];
  assign wdt_expire   = is_armed & ~accept & (wdt == WDT_LAST);

  assign armed    = (state == ST_ARMED);
  assign failsafe = (state == ST_FAILSAFE);

  assign duty0_o = duty_q[0];
  assign duty1_o = duty_q[1];
  assign duty2_o = duty_q[2];
  assign duty3_o = duty_q[3];

  // MCU shadow as seen by a same-cycle commit: a concurrent write bypasses in.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mcu_eff[i] = (mcu_wr && (mcu_ch == 2'(i))) ? mcu_duty : mcu_shadow[i];
    end
  end

  // Per-source duty shadows; each source can only write its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pi_shadow[i]  <= SAFE_DUTY;
        mcu_shadow[i] <= SAFE_DUTY;
      end
    end else begin
      if (wb_wr && !adr[2]) pi_shadow[adr[1:0]] <= DUTY_WIDTH'(wb_dat_i);
      if (mcu_wr) mcu_shadow[mcu_ch] <= mcu_duty;
    end
  end

  // Arm/failsafe state machine, ownership, watchdog and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_DISARMED;
      owner      <= 1'b0;
      arm_req    <= 1'b0;
      drop_count <= 8'd0;
      wdt        <= '0;
    end else begin
      if (ctrl_wr) begin
        arm_req <= wb_dat_i[0];
        // Ownership can only change while the motors are disarmed.
        if (state == ST_DISARMED) owner <= wb_dat_i[1];
      end
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      case (state)
        ST_DISARMED: begin
          if (arm_next) begin
            state <= ST_ARMED;
            wdt   <= '0;
          end
        end
        ST_ARMED: begin
          if (disarm_req) begin
            state <= ST_DISARMED;
            wdt   <= '0;
          end else if (accept) begin
            wdt <= '0;
          end else if (wdt == WDT_LAST) begin
            state <= ST_FAILSAFE;
            wdt   <= '0;
          end else begin
            wdt <= wdt + 1'b1;
          end
        end
        ST_FAILSAFE: begin
          if (ctrl_wr && wb_dat_i[2] && !wb_dat_i[0]) state <= ST_DISARMED;
        end
        default: state <= ST_DISARMED;
      endcase
    end
  end

  // Committed duties: owner frame on accept, safe duty on disarm or expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) duty_q[i] <= SAFE_DUTY;
      duty_upd <= 1'b0;
    end else begin
      duty_upd <= 1'b0;
      if (disarm_req || wdt_expire) begin
        for (int i = 0; i < 4; i++) duty_q[i] <= SAFE_DUTY;
        duty_upd <= 1'b1;
      end else if (accept) begin
        for (int i = 0; i < 4; i++) duty_q[i] <= owner ? mcu_eff[i] : pi_shadow[i];
        duty_upd <= 1'b1;
      end
    end
  end

  // Registered Wishbone read data, held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_dat_o <= 16'd0;
    end else if (wb_rd) begin
      case (adr)
        3'd0, 3'd1, 3'd2, 3'd3: wb_dat_o <= 16'(pi_shadow[adr[1:0]]);
        3'd5:                   wb_dat_o <= {14'd0, owner, arm_req};
        3'd6:                   wb_dat_o <= {drop_count, 5'd0, owner, state};
        default:                wb_dat_o <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cmd_arbiter.sv
// Directed bench for pwm_cmd_arbiter with a short watchdog (16 cycles).
module tb_pwm_cmd_arbiter;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          wb_stb_i, wb_cyc_i, wb_we_i;
  logic [13:0]   wb_adr_i;
  logic [15:0]   wb_dat_i;
  logic [15:0]   wb_dat_o;
  logic          mcu_wr;
  logic [1:0]    mcu_ch;
  logic [DW-1:0] mcu_duty;
  logic          mcu_commit;
  logic [DW-1:0] duty0_o, duty1_o, duty2_o, duty3_o;
  logic          duty_upd, armed, failsafe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rd;

  pwm_cmd_arbiter #(
    .DUTY_WIDTH(DW),
    .WDT_CYCLES(16),
    .SAFE_DUTY (16'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .mcu_wr    (mcu_wr),
    .mcu_ch    (mcu_ch),
    .mcu_duty  (mcu_duty),
    .mcu_commit(mcu_commit),
    .duty0_o   (duty0_o),
    .duty1_o   (duty1_o),
    .duty2_o   (duty2_o),
    .duty3_o   (duty3_o),
    .duty_upd  (duty_upd),
    .armed     (armed),
    .failsafe  (failsafe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = {11'd0, a}; wb_dat_i = d;
    tick();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [15:0] d);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = {11'd0, a};
    tick();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    d = wb_dat_o;
  endtask

  task automatic mcu_write(input logic [1:0] ch, input logic [DW-1:0] d);
    mcu_wr = 1'b1; mcu_ch = ch; mcu_duty = d;
    tick();
    mcu_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0;
    mcu_wr = 1'b0; mcu_ch = '0; mcu_duty = '0; mcu_commit = 1'b0;
    tick();
    tick();
    check("rst_duty0", duty0_o, 0);
    check("rst_armed", armed, 0);
    check("rst_failsafe", failsafe, 0);
    check("rst_upd", duty_upd, 0);
    check("rst_wbdat", wb_dat_o, 0);
    reset = 1'b0;
    tick();
    wb_read(3'd6, rd);
    check("rst_status", rd, 16'h0000);

    // Arm with owner Pi, load a frame and commit it.
    wb_write(3'd5, 16'h0001);
    check("arm_pi", armed, 1);
    wb_write(3'd0, 16'd100);
    wb_write(3'd1, 16'd200);
    wb_write(3'd2, 16'd300);
    wb_write(3'd3, 16'd400);
    check("safe_until_commit", duty0_o, 0);
    wb_write(3'd4, 16'h0000);
    check("pi_d0", duty0_o, 100);
    check("pi_d1", duty1_o, 200);
    check("pi_d2", duty2_o, 300);
    check("pi_d3", duty3_o, 400);
    check("pi_upd", duty_upd, 1);
    tick();
    check("pi_upd_once", duty_upd, 0);
    wb_read(3'd6, rd);
    check("status_armed_pi", rd, 16'h0001);
    wb_read(3'd1, rd);
    check("pi_shadow1_rd", rd, 16'd200);

    // Non-owner MCU commits are dropped and counted.
    mcu_commit = 1'b1;
    tick(); tick(); tick();
    mcu_commit = 1'b0;
    check("drop_d0_hold", duty0_o, 100);
    check("drop_no_upd", duty_upd, 0);
    wb_read(3'd6, rd);
    check("drop3_status", rd, 16'h0301);
    // Same-cycle commits from both keep the watchdog fed while saturating.
    for (int i = 0; i < 300; i++) begin
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 14'd4; wb_dat_i = 16'd0;
      mcu_commit = 1'b1;
      tick();
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    mcu_commit = 1'b0;
    wb_read(3'd6, rd);
    check("drop_saturate", rd, 16'hFF01);
    check("sat_d3_hold", duty3_o, 400);

    // Reset while armed with live duties.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_d0", duty0_o, 0);
    check("midrst_d3", duty3_o, 0);
    check("midrst_armed", armed, 0);
    check("midrst_upd", duty_upd, 0);
    check("midrst_wbdat", wb_dat_o, 0);
    wb_read(3'd6, rd);
    check("midrst_status", rd, 16'h0000);
    wb_read(3'd3, rd);
    check("midrst_shadow", rd, 16'd0);

    // Owner MCU, bypassed write+commit alongside a dropped Pi commit.
    wb_write(3'd5, 16'h0002);
    wb_read(3'd6, rd);
    check("owner_mcu_status", rd, 16'h0004);
    mcu_write(2'd0, 16'd11);
    mcu_write(2'd1, 16'd22);
    mcu_write(2'd2, 16'd33);
    mcu_write(2'd3, 16'd44);
    wb_write(3'd5, 16'h0003);
    check("arm_mcu", armed, 1);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 14'd4; wb_dat_i = 16'd0;
    mcu_wr = 1'b1; mcu_ch = 2'd2; mcu_duty = 16'd777; mcu_commit = 1'b1;
    tick();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    mcu_wr = 1'b0; mcu_commit = 1'b0;
    check("mcu_d0", duty0_o, 11);
    check("mcu_d1", duty1_o, 22);
    check("mcu_bypass_d2", duty2_o, 777);
    check("mcu_d3", duty3_o, 44);
    check("mcu_upd", duty_upd, 1);
    wb_read(3'd6, rd);
    check("both_commit_status", rd, 16'h0105);
    wb_write(3'd5, 16'h0001);
    wb_read(3'd6, rd);
    check("srcsel_ignored_armed", rd, 16'h0105);

    // Watchdog: commit on the last count holds off failsafe, then expire.
    mcu_commit = 1'b1;
    tick();
    mcu_commit = 1'b0;
    check("wdt_commit_upd", duty_upd, 1);
    repeat (15) tick();
    check("wdt_pre_fs", failsafe, 0);
    check("wdt_pre_armed", armed, 1);
    mcu_commit = 1'b1;
    tick();
    mcu_commit = 1'b0;
    check("wdt_last_commit_fs", failsafe, 0);
    check("wdt_last_commit_upd", duty_upd, 1);
    repeat (15) tick();
    check("wdt_15_idle", failsafe, 0);
    tick();
    check("wdt_expire_fs", failsafe, 1);
    check("wdt_expire_armed", armed, 0);
    check("wdt_expire_upd", duty_upd, 1);
    check("wdt_expire_d2", duty2_o, 0);
    tick();
    check("wdt_upd_once", duty_upd, 0);
    wb_read(3'd6, rd);
    check("fs_status", rd, 16'h0106);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 14'd4; wb_dat_i = 16'd0;
    mcu_commit = 1'b1;
    tick();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    mcu_commit = 1'b0;
    check("fs_commit_ignored", duty2_o, 0);
    check("fs_commit_no_upd", duty_upd, 0);
    wb_read(3'd6, rd);
    check("fs_no_count", rd, 16'h0106);

    // Failsafe recovery and ownership rules.
    wb_write(3'd5, 16'h0005);
    check("fs_hold_0x5", failsafe, 1);
    wb_write(3'd5, 16'h0004);
    check("fs_clear", failsafe, 0);
    check("fs_clear_armed", armed, 0);
    wb_read(3'd6, rd);
    check("disarmed_status", rd, 16'h0104);
    wb_write(3'd5, 16'h0000);
    wb_read(3'd6, rd);
    check("owner_pi_again", rd, 16'h0100);
    wb_write(3'd5, 16'h0002);
    wb_read(3'd6, rd);
    check("owner_mcu_again", rd, 16'h0104);
    wb_read(3'd5, rd);
    check("ctrl_rd", rd, 16'h0002);
    wb_read(3'd7, rd);
    check("reserved_rd", rd, 16'h0000);
    wb_read(3'd4, rd);
    check("commit_rd", rd, 16'h0000);
    wb_write(3'd5, 16'h0003);
    wb_write(3'd5, 16'h0001);
    check("rearm", armed, 1);
    wb_read(3'd6, rd);
    check("srcsel_armed_final", rd, 16'h0105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_cmd_arbiter.md
Name: pwm_cmd_arbiter

Overview:
- Sits between the two motor-command sources and the 4-channel PWM stage.
- Sources: Raspberry Pi, via a Wishbone slave on the free conbus slot s3 (0x1800), and the SAM MCU, via a direct write port.
- Each source fills a private 4-channel duty shadow and then requests a frame commit. Only the committing source that currently owns the motors is granted; the other source's commits are dropped and counted.
- An arm/failsafe state machine with a command watchdog forces the outputs to a safe duty when the owner stops committing.

Parameters:
- DUTY_WIDTH, 16: width of each duty command.
- WDT_CYCLES, 20000000: clk cycles without an accepted commit before failsafe (100 ms at 200 MHz).
- SAFE_DUTY, 0: duty driven on all channels when disarmed or in failsafe.

Ports:
- clk  in  1  system clock (200 MHz domain).
- reset  in  1  synchronous, active-high reset.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  14  Wishbone word address; only [2:0] decoded.
- wb_dat_i  in  16  Wishbone write data.
- wb_dat_o  out  16  Wishbone read data, registered.
- mcu_wr  in  1  MCU shadow write strobe, 1 cycle.
- mcu_ch  in  2  MCU target channel.
- mcu_duty  in  DUTY_WIDTH  MCU duty value.
- mcu_commit  in  1  MCU frame commit request, 1 cycle.
- duty0_o, duty1_o, duty2_o, duty3_o  out  DUTY_WIDTH each  committed duties to the PWM stage.
- duty_upd  out  1  one-cycle pulse when duty*_o change.
- armed  out  1  high in ARMED.
- failsafe  out  1  high in FAILSAFE.

Behaviour:
- Wishbone access: a transfer occurs when wb_stb_i & wb_cyc_i. No ack port exists. Writes take effect at that edge. Reads return on wb_dat_o one cycle later and hold until the next access.
- Register map, by wb_adr_i[2:0]:
  - 0-3: Pi shadow duty for ch0-3 (R/W).
  - 4: COMMIT. Any write is a Pi commit request. Reads return 0.
  - 5: CTRL (R/W). bit0 arm_req; bit1 src_sel (0 = Pi, 1 = MCU); bit2 clr_fault (write-only, reads 0).
  - 6: STATUS (RO). [1:0] state (0 = DISARMED, 1 = ARMED, 2 = FAILSAFE); [2] owner; [15:8] drop_count.
  - 7: reserved, reads 0.
- MCU shadow: when mcu_wr is high, MCU shadow[mcu_ch] <= mcu_duty.
- Same-cycle write and commit: if mcu_wr and mcu_commit are both high, the commit uses the new value (bypass). The same rule applies to a Pi shadow write coinciding with an MCU commit only for the MCU's own shadow; shadows are never shared.
- Ownership: owner <= src_sel only when a CTRL write occurs in DISARMED. In ARMED or FAILSAFE the src_sel bit of a CTRL write is ignored, while the arm_req and clr_fault bits still apply.
- Commit arbitration, evaluated each cycle when state is ARMED:
  - An owner commit is accepted. duty*_o <= owner shadow and duty_upd = 1 take effect at the next edge (1-cycle latency). The watchdog counter is cleared.
  - A non-owner commit is dropped and drop_count is incremented, saturating at 255.
  - If both sources commit in the same cycle, the owner's is accepted and the other's is dropped (+1).
- Commits outside ARMED are ignored and not counted.
- Watchdog:
  - Counts only in ARMED, incrementing each cycle without an accepted commit.
  - Reaching WDT_CYCLES-1 moves the state to FAILSAFE on the next edge.
  - An accepted commit in the same cycle that the count reaches WDT_CYCLES-1 wins: no failsafe.
- State transitions:
  - DISARMED -> ARMED: arm_req = 1 (written or held). Watchdog cleared. Outputs stay SAFE_DUTY until the first accepted commit.
  - ARMED -> DISARMED: arm_req written 0. Outputs <= SAFE_DUTY with a duty_upd pulse.
  - ARMED -> FAILSAFE: watchdog expiry. Outputs <= SAFE_DUTY with a duty_upd pulse. arm_req is left unchanged.
  - FAILSAFE -> DISARMED: a CTRL write with clr_fault = 1 and arm_req = 0. Any other CTRL write keeps FAILSAFE, updating only the stored arm_req.
- Reset, synchronous and taking precedence over everything, mid-frame included:
  - duty*_o = SAFE_DUTY, duty_upd = 0, armed = 0, failsafe = 0, wb_dat_o = 0.
  - State DISARMED, owner = Pi, arm_req = 0.
  - Both shadows = SAFE_DUTY, drop_count = 0, watchdog = 0.

Test Plan:
- Reset, then arm with owner Pi. Write Pi duties 100, 200, 300, 400, then COMMIT -> one cycle later duty0..3_o = 100/200/300/400, duty_upd high for exactly 1 cycle, STATUS = 0x0001.
- Owner Pi, armed, MCU commits 3 times -> outputs unchanged, STATUS[15:8] = 3. Then 300 MCU commits -> drop_count saturates at 255.
- Same-cycle Pi COMMIT and mcu_commit with owner MCU; MCU writes ch2 = 777 with mcu_wr and mcu_commit together -> duty2_o = 777, drop_count +1.
- Run with WDT_CYCLES = 16, arm, one commit, then idle -> failsafe rises 16 cycles after the commit, outputs = SAFE_DUTY with a duty_upd pulse. A commit landing on cycle 15 instead prevents failsafe.
- In FAILSAFE: write CTRL = 0x0005 -> remains FAILSAFE. Write CTRL = 0x0004 -> DISARMED. Then CTRL = 0x0002 (src_sel) -> owner = MCU. Writing src_sel while ARMED -> owner unchanged.
- Assert reset while ARMED with non-safe duties -> the next cycle shows all outputs at SAFE_DUTY, state DISARMED, owner Pi, drop_count 0.
